// File: rtl/fifo_access_scheduler.sv
// Purpose: shares one pixel FIFO between N_REQ round-robin writers and drains it in fixed bursts.
// Latency: write grant is combinational; burst accept at edge T -> first fifo_rd in T+1 -> first out_valid in T+2.
// Backpressure: writers are held off (req_ready=0) whenever the FIFO is full; bursts only start when BURST_LEN bytes are present.
module fifo_access_scheduler #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 9,
    parameter int DEPTH     = 256,
    parameter int BURST_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [2:0]                grant_id,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      fifo_rd,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    input  logic [CNT_W-1:0]          fifo_count,
    input  logic [DATA_W-1:0]         fifo_dout,
    input  logic                      burst_req,
    output logic                      burst_busy,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last
);

    // Burst counter must reach BURST_LEN-1, and BURST_LEN may be as large as DEPTH.
    localparam int BC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BC_W-1:0]   bcnt;
    logic              last_rd;
    logic [2:0]        rr_ptr;
    logic [2:0]        winner;
    logic              any_vld;
    logic              accept_en;

    // Round-robin search: the lowest offset from rr_ptr with a valid request wins.
    always_comb begin
        winner  = rr_ptr;
        any_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ((i == ((int'(rr_ptr) + k) % N_REQ)) && req_valid[i]) begin
                    winner  = 3'(i);
                    any_vld = 1'b1;
                end
            end
        end
    end

    // Ready is also forced low while reset is asserted so no writer sees a handshake during reset.
    assign accept_en = any_vld && rst_n && !fifo_full;

    // One-hot ready to the winner and a data mux selecting its byte.
    always_comb begin
        req_ready = '0;
        fifo_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == 3'(i)) begin
                req_ready[i] = accept_en;
                fifo_din     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign fifo_wr = |(req_valid & req_ready);

    // Pointer moves past the accepted writer; grant_id remembers who it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (fifo_wr) begin
            rr_ptr   <= (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
            grant_id <= winner;
        end
    end

    // Burst FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst FSM next state and strobes; burst_req is only looked at in IDLE.
    always_comb begin
        state_nxt  = state;
        fifo_rd    = 1'b0;
        burst_busy = 1'b0;
        last_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (burst_req && (fifo_count >= CNT_W'(BURST_LEN))) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                fifo_rd    = 1'b1;
                burst_busy = 1'b1;
                if (bcnt == BC_W'(BURST_LEN - 1)) begin
                    last_rd   = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                burst_busy = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counts read strobes within a burst; parked at zero outside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
        end else if (state == IDLE) begin
            bcnt <= '0;
        end else if (fifo_rd) begin
            bcnt <= bcnt + BC_W'(1);
        end
    end

    // FIFO read data appears one cycle after the strobe, so valid/last are the strobes delayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= fifo_rd;
            out_last  <= last_rd;
        end
    end

    assign out_data = fifo_dout;

    // Entry is gated on occupancy and nothing else reads, so a read can never hit an empty FIFO.
    a_no_rd_empty: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_rd && fifo_empty));

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Bench for fifo_access_scheduler: behavioural 256x8 FIFO, arbiter vector table, burst sequences.
// Expected output bytes are queued when written and popped as out_valid appears.
// Runs to completion on its own with a global time bound.
module tb_fifo_access_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [2:0]  grant_id;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic        fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  fcnt;
    logic [7:0]  fdout;
    logic        burst_req;
    logic        burst_busy;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];

    fifo_access_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .grant_id   (grant_id),
        .fifo_wr    (fifo_wr),
        .fifo_din   (fifo_din),
        .fifo_rd    (fifo_rd),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fcnt),
        .fifo_dout  (fdout),
        .burst_req  (burst_req),
        .burst_busy (burst_busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 256x8 synchronous FIFO sharing the DUT reset.
    logic [7:0] mem [256];
    logic [7:0] wp;
    logic [7:0] rp;
    assign fifo_full  = (fcnt == 9'd256);
    assign fifo_empty = (fcnt == 9'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            fcnt  <= '0;
            fdout <= '0;
        end else begin
            if (fifo_wr) begin
                mem[wp] <= fifo_din;
                wp      <= wp + 8'd1;
            end
            if (fifo_rd) begin
                fdout <= mem[rp];
                rp    <= rp + 8'd1;
            end
            fcnt <= fcnt + 9'(fifo_wr) - 9'(fifo_rd);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: valid follows read strobe, data from scoreboard, last on every 16th beat.
    logic prev_rd;
    int   beat;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
            beat    = 0;
        end else begin
            chk("out_valid_vs_rd", 32'(out_valid), 32'(prev_rd));
            if (fifo_rd) chk("rd_on_empty", 32'(fifo_empty), 32'd0);
            if (fifo_wr) chk("wr_on_full", 32'(fifo_full), 32'd0);
            if (out_valid) begin
                beat++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got out_data %0h expected no output", out_data);
                end else begin
                    chk("out_data", 32'(out_data), 32'(sb.pop_front()));
                end
                chk("out_last", 32'(out_last), 32'(beat == 16));
                if (beat == 16) beat = 0;
            end else begin
                chk("out_last_idle", 32'(out_last), 32'd0);
            end
            prev_rd = fifo_rd;
        end
    end

    task automatic write_one(input int idx, input logic [7:0] d);
        req_valid = 4'(1 << idx);
        req_data[idx*8 +: 8] = d;
        #1;
        chk("wr_one_rdy", 32'(req_ready), 32'(1 << idx));
        sb.push_back(d);
        tick();
        req_valid = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (burst_busy && n < 40) begin
            tick();
            n++;
        end
        chk("burst_ends", 32'(burst_busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0] vld;
        logic [3:0] rdy;
        logic [7:0] din;
        logic [2:0] gid;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rdc, ovc, wr_n, full_n;

        // Vectors from reset state (rr_ptr=0); gid is grant_id after the edge.
        tbl[0]  = '{4'hF, 4'h1, 8'hA0, 3'd0};
        tbl[1]  = '{4'hF, 4'h2, 8'hA1, 3'd1};
        tbl[2]  = '{4'hF, 4'h4, 8'hA2, 3'd2};
        tbl[3]  = '{4'hF, 4'h8, 8'hA3, 3'd3};
        tbl[4]  = '{4'hF, 4'h1, 8'hA0, 3'd0};
        tbl[5]  = '{4'hF, 4'h2, 8'hA1, 3'd1};
        tbl[6]  = '{4'h0, 4'h0, 8'h00, 3'd1};
        tbl[7]  = '{4'h9, 4'h8, 8'hA3, 3'd3};
        tbl[8]  = '{4'h6, 4'h2, 8'hA1, 3'd1};
        tbl[9]  = '{4'h2, 4'h2, 8'hA1, 3'd1};
        tbl[10] = '{4'h1, 4'h1, 8'hA0, 3'd0};
        tbl[11] = '{4'hC, 4'h4, 8'hA2, 3'd2};

        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        burst_req = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fifo_wr",   32'(fifo_wr),   32'd0);
        chk("rst_fifo_rd",   32'(fifo_rd),   32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_busy",      32'(burst_busy), 32'd0);
        chk("rst_grant_id",  32'(grant_id),  32'd0);
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Arbiter vector table.
        req_data = 32'hA3A2A1A0;
        for (int v = 0; v < 12; v++) begin
            req_valid = tbl[v].vld;
            #1;
            chk("tbl_ready", 32'(req_ready), 32'(tbl[v].rdy));
            chk("tbl_wr",    32'(fifo_wr),   32'(tbl[v].rdy != 4'h0));
            if (tbl[v].rdy != 4'h0) begin
                chk("tbl_din", 32'(fifo_din), 32'(tbl[v].din));
                sb.push_back(tbl[v].din);
            end
            tick();
            req_valid = '0;
            chk("tbl_gid", 32'(grant_id), 32'(tbl[v].gid));
        end

        // Top up to 20 bytes from writer 1.
        for (int k = 0; k < 9; k++) write_one(1, 8'(8'h10 + k));
        chk("count_20", 32'(fcnt), 32'd20);

        // Single burst from count 20.
        burst_req = 1'b1;
        tick();
        burst_req = 1'b0;
        #1;
        chk("lat_first_rd", 32'(fifo_rd),   32'd1);
        chk("lat_first_ov", 32'(out_valid), 32'd0);
        rdc = 0;
        ovc = 0;
        for (int c = 0; c < 30; c++) begin
            if (fifo_rd)   rdc++;
            if (out_valid) ovc++;
            tick();
            #1;
        end
        chk("burst_rd_cycles", 32'(rdc), 32'd16);
        chk("burst_ov_cycles", 32'(ovc), 32'd16);
        chk("count_after_burst", 32'(fcnt), 32'd4);

        // Count 15 with burst_req held: no start until the 16th byte lands.
        for (int k = 0; k < 11; k++) write_one(2, 8'(8'h40 + k));
        burst_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("hold15_busy", 32'(burst_busy), 32'd0);
            chk("hold15_rd",   32'(fifo_rd),    32'd0);
            tick();
        end
        write_one(2, 8'h4B);
        #1;
        chk("cnt16_still_idle", 32'(burst_busy), 32'd0);
        tick();
        #1;
        chk("cnt16_read", 32'(burst_busy), 32'd1);
        chk("cnt16_rd",   32'(fifo_rd),    32'd1);
        wait_idle();
        burst_req = 1'b0;
        tick();
        chk("count_zero", 32'(fcnt), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Writer 2 alone for 300 cycles: fills to 256 then is held off.
        wr_n   = 0;
        full_n = 0;
        req_valid = 4'h4;
        for (int c = 0; c < 300; c++) begin
            req_data[23:16] = 8'(wr_n);
            #1;
            if (fcnt == 9'd256) begin
                chk("full_ready", 32'(req_ready), 32'd0);
                chk("full_wr",    32'(fifo_wr),   32'd0);
                full_n++;
            end else if (fifo_wr) begin
                sb.push_back(8'(wr_n));
                wr_n++;
            end
            tick();
        end
        chk("fill_writes", 32'(wr_n),   32'd256);
        chk("full_cycles", 32'(full_n), 32'd44);

        // Burst from a full FIFO with writer 2 still pushing.
        burst_req = 1'b1;
        tick();
        burst_req = 1'b0;
        req_data[23:16] = 8'(wr_n);
        #1;
        chk("full_rd1_rd",    32'(fifo_rd),   32'd1);
        chk("full_rd1_wr",    32'(fifo_wr),   32'd0);
        chk("full_rd1_ready", 32'(req_ready), 32'd0);
        tick();
        for (int c = 0; c < 15; c++) begin
            req_data[23:16] = 8'(wr_n);
            #1;
            chk("overlap_rd", 32'(fifo_rd), 32'd1);
            chk("overlap_wr", 32'(fifo_wr), 32'd1);
            sb.push_back(8'(wr_n));
            wr_n++;
            tick();
            chk("overlap_count", 32'(fcnt), 32'd255);
        end
        req_data[23:16] = 8'(wr_n);
        #1;
        chk("drain_rd", 32'(fifo_rd), 32'd0);
        chk("drain_wr", 32'(fifo_wr), 32'd1);
        sb.push_back(8'(wr_n));
        wr_n++;
        tick();
        chk("refull_count", 32'(fcnt), 32'd256);

        // Reset in the middle of a burst.
        burst_req = 1'b1;
        tick();
        burst_req = 1'b0;
        req_valid = 4'hF;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_fifo_rd",   32'(fifo_rd),   32'd0);
        chk("midrst_ready",     32'(req_ready), 32'd0);
        chk("midrst_busy",      32'(burst_busy), 32'd0);
        tick();
        rst_n    = 1'b1;
        req_data = 32'hA3A2A1A0;
        #1;
        chk("post_rst_ready0", 32'(req_ready), 32'd1);
        chk("post_rst_din0",   32'(fifo_din),  32'hA0);
        sb.push_back(8'hA0);
        tick();
        chk("post_rst_gid0",   32'(grant_id),  32'd0);
        chk("post_rst_ready1", 32'(req_ready), 32'd2);
        sb.push_back(8'hA1);
        tick();
        req_valid = '0;
        chk("post_rst_count", 32'(fcnt), 32'd2);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
